cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle instruction sequencer for the 16-bit CPU. It fetches an instruction word over a req/ack port, decodes the 5-bit opcode, and drives ALU op/operand selects, register-file read and write controls, the data-memory handshake and the PC. It sits between instruction/data memory and the register file + ALU datapath. It holds no datapath values except the PC and IR.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset
MEM_TIMEOUT, 255, max cycles waiting for imem_ack/dmem_ack before fault (1..255)

Ports:
CLK  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  16  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  16  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store (STW), 0 = load (LDW)
dmem_ack  in  1  data access complete
alu_op  out  4  0 IDLE,1 ADD,2 SUB,3 OR,4 AND,5 XOR,6 SL,7 SR,8 GT,9 LT,10 EQ
alu_imm_sel  out  1  1 = ALU in_b takes alu_imm
alu_imm  out  16  zero-extended IR[15:8]
rf_ra  out  3  read port A index
rf_rb  out  3  read port B index
rf_we  out  1  register write strobe (one cycle)
rf_wa  out  3  write index
rf_wd_sel  out  1  0 = ALU result, 1 = dmem read data
pc  out  16  program counter
busy  out  1  high unless in HALT
fault  out  1  sticky: illegal opcode or memory timeout

Behaviour:
- Reset (reset==0 at a CLK edge) has priority in every state and aborts any pending handshake next cycle.
- Reset values: state=FETCH, pc=PC_RESET, IR=0, fault=0, busy=1. All strobes and selects are 0: req, we, rf_we, alu_op=IDLE.
- IR format: opcode IR[4:0]; rd IR[7:5]; ra IR[10:8]; rb IR[13:11]; imm8 IR[15:8].
- R-type (opcodes 0-6, 15-17): rd <= ra op rb. Operations ADD, SUB, OR, AND, XOR, SL, SR, GT, LT, EQ.
- I-type (opcodes 7-13): rd <= rd op zext(imm8). Register A index = rd.
- BR (14): pc <= pc + 1 + sext(imm8). No register write.
- STW (18): mem[ra] <= rd; rf_ra=ra, rf_rb=rd.
- LDW (19): rd <= mem[ra].
- Opcodes 20-31 are illegal.
- States:
  - FETCH: imem_req=1. On imem_ack, IR <= imem_rdata and go to DECODE. The same-cycle ack is accepted.
  - DECODE: drive rf_ra/rf_rb/alu_imm from IR. Illegal opcode -> HALT with fault=1. BR -> update pc, then FETCH. STW/LDW -> MEM. Otherwise -> EXEC.
  - EXEC: drive alu_op and alu_imm_sel for one cycle (the ALU registers its output) -> WB.
  - WB: rf_we=1, rf_wa=rd, rf_wd_sel=0; pc <= pc+1 -> FETCH.
  - MEM: dmem_req=1, dmem_we as per opcode; hold ra/rb selects. On dmem_ack: for LDW, rf_we=1, rf_wd_sel=1, rf_wa=rd in the ack cycle. Then pc <= pc+1 -> FETCH.
  - HALT: all strobes 0, busy=0; leave only by reset.
- Handshakes:
  - req stays high until ack. Ack while req is low is ignored.
  - A per-access wait counter resets on entry to FETCH/MEM. If it reaches MEM_TIMEOUT without ack -> HALT, fault=1.
- Latency with zero-wait memories:
  - ALU instruction: 4 cycles.
  - BR: 2 cycles.
  - LDW/STW: 3 cycles.
- Arithmetic:
  - pc wraps modulo 2^16 (16'hFFFF+1 = 0).
  - Branch offset is two's-complement −128..+127 relative to pc+1.
- Outputs are registered or state-decoded with no combinational path from ack to req.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_LDW;
  - ALU op constants IDLE..EQ;
  - state encoding;
  - IR field bit positions.
- The ALU reuses these constants.
- One sub-module, cpu_decode: purely combinational opcode -> {alu_op, imm_sel, class (ALU/BR/MEM/ILLEGAL), is_store}.
- The FSM, PC, IR and timeout counter stay in cpu_ctrl_fsm.

Test Plan:
- ADDI: IR=16'h05_E7 (opcode 7, rd=7, imm=5), zero-wait ack -> alu_op=1, alu_imm_sel=1, alu_imm=5 in EXEC; rf_we with rf_wa=7 on cycle 4; pc 0->1.
- BR backward: pc=16'h0010, IR imm8=8'hFE -> pc=16'h000F after 2 cycles, no rf_we. Repeat with pc=16'hFFFF and imm=0 -> pc=0.
- LDW with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0. rf_we=1 with rf_wd_sel=1 only in the ack cycle.
- Illegal opcode 5'd25 -> HALT after DECODE; fault=1, busy=0, no further imem_req; reset low for 1 cycle -> pc=PC_RESET, fault=0.
- imem_ack never arrives, MEM_TIMEOUT=4 -> fault=1 after 4 waiting cycles. A spurious dmem_ack in FETCH is ignored.
- Reset asserted mid-MEM with dmem_req high -> next cycle dmem_req=0, state FETCH, pc=PC_RESET, no rf_we.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, ALU operations,
// sequencer state encoding and instruction-word field helpers.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SL   = 5'd5;
    localparam logic [4:0] OP_SR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_SUBI = 5'd8;
    localparam logic [4:0] OP_ORI  = 5'd9;
    localparam logic [4:0] OP_ANDI = 5'd10;
    localparam logic [4:0] OP_XORI = 5'd11;
    localparam logic [4:0] OP_SLI  = 5'd12;
    localparam logic [4:0] OP_SRI  = 5'd13;
    localparam logic [4:0] OP_BR   = 5'd14;
    localparam logic [4:0] OP_GT   = 5'd15;
    localparam logic [4:0] OP_LT   = 5'd16;
    localparam logic [4:0] OP_EQ   = 5'd17;
    localparam logic [4:0] OP_STW  = 5'd18;
    localparam logic [4:0] OP_LDW  = 5'd19;

    localparam logic [3:0] ALU_IDLE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SL   = 4'd6;
    localparam logic [3:0] ALU_SR   = 4'd7;
    localparam logic [3:0] ALU_GT   = 4'd8;
    localparam logic [3:0] ALU_LT   = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam int IR_OP_LSB  = 0;
    localparam int IR_RD_LSB  = 5;
    localparam int IR_RA_LSB  = 8;
    localparam int IR_RB_LSB  = 11;
    localparam int IR_IMM_LSB = 8;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_BR      = 2'd1,
        CLS_MEM     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } instr_class_e;

    function automatic logic [4:0] ir_opcode(input logic [15:0] ir);
        return ir[IR_OP_LSB +: 5];
    endfunction

    function automatic logic [2:0] ir_rd(input logic [15:0] ir);
        return ir[IR_RD_LSB +: 3];
    endfunction

    function automatic logic [2:0] ir_ra(input logic [15:0] ir);
        return ir[IR_RA_LSB +: 3];
    endfunction

    function automatic logic [2:0] ir_rb(input logic [15:0] ir);
        return ir[IR_RB_LSB +: 3];
    endfunction

    function automatic logic [7:0] ir_imm8(input logic [15:0] ir);
        return ir[IR_IMM_LSB +: 8];
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: maps a 5-bit opcode to its ALU operation,
// immediate select, instruction class and store flag.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [4:0]   opcode,
    output logic [3:0]   alu_op,
    output logic         imm_sel,
    output instr_class_e iclass,
    output logic         is_store
);

    // Opcode table; anything not listed falls through to the illegal class.
    always_comb begin
        alu_op   = ALU_IDLE;
        imm_sel  = 1'b0;
        iclass   = CLS_ILLEGAL;
        is_store = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_op = ALU_ADD; iclass = CLS_ALU; end
            OP_SUB:  begin alu_op = ALU_SUB; iclass = CLS_ALU; end
            OP_OR:   begin alu_op = ALU_OR;  iclass = CLS_ALU; end
            OP_AND:  begin alu_op = ALU_AND; iclass = CLS_ALU; end
            OP_XOR:  begin alu_op = ALU_XOR; iclass = CLS_ALU; end
            OP_SL:   begin alu_op = ALU_SL;  iclass = CLS_ALU; end
            OP_SR:   begin alu_op = ALU_SR;  iclass = CLS_ALU; end
            OP_GT:   begin alu_op = ALU_GT;  iclass = CLS_ALU; end
            OP_LT:   begin alu_op = ALU_LT;  iclass = CLS_ALU; end
            OP_EQ:   begin alu_op = ALU_EQ;  iclass = CLS_ALU; end
            OP_ADDI: begin alu_op = ALU_ADD; imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_SUBI: begin alu_op = ALU_SUB; imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_ORI:  begin alu_op = ALU_OR;  imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_ANDI: begin alu_op = ALU_AND; imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_XORI: begin alu_op = ALU_XOR; imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_SLI:  begin alu_op = ALU_SL;  imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_SRI:  begin alu_op = ALU_SR;  imm_sel = 1'b1; iclass = CLS_ALU; end
            OP_BR:   begin iclass = CLS_BR; end
            OP_STW:  begin iclass = CLS_MEM; is_store = 1'b1; end
            OP_LDW:  begin iclass = CLS_MEM; end
            default: begin iclass = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, write-back and
// data-memory access, owning only the PC, IR, fault flag and wait counter.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET    = 16'h0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [3:0]  alu_op,
    output logic        alu_imm_sel,
    output logic [15:0] alu_imm,
    output logic [2:0]  rf_ra,
    output logic [2:0]  rf_rb,
    output logic        rf_we,
    output logic [2:0]  rf_wa,
    output logic        rf_wd_sel,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fault
);

    // Counter value on the last permitted waiting cycle of a handshake.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    logic [2:0]   state_r;
    logic [15:0]  pc_r;
    logic [15:0]  ir_r;
    logic         fault_r;
    logic [7:0]   wait_r;

    logic [3:0]   dec_alu_op_s;
    logic         dec_imm_sel_s;
    instr_class_e dec_class_s;
    logic         dec_is_store_s;
    logic [15:0]  pc_inc_s;
    logic [15:0]  pc_br_s;

    cpu_decode u_decode (
        .opcode   (ir_opcode(ir_r)),
        .alu_op   (dec_alu_op_s),
        .imm_sel  (dec_imm_sel_s),
        .iclass   (dec_class_s),
        .is_store (dec_is_store_s)
    );

    assign pc_inc_s = pc_r + 16'd1;
    assign pc_br_s  = pc_inc_s + sext8(ir_imm8(ir_r));

    // Sequencer state, PC, IR, sticky fault and per-access wait counter.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_r <= ST_FETCH;
            pc_r    <= PC_RESET;
            ir_r    <= 16'h0000;
            fault_r <= 1'b0;
            wait_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_r    <= imem_rdata;
                        state_r <= ST_DECODE;
                    end else if (wait_r == TIMEOUT_LAST) begin
                        state_r <= ST_HALT;
                        fault_r <= 1'b1;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                ST_DECODE: begin
                    case (dec_class_s)
                        CLS_ILLEGAL: begin
                            state_r <= ST_HALT;
                            fault_r <= 1'b1;
                        end
                        CLS_BR: begin
                            pc_r    <= pc_br_s;
                            state_r <= ST_FETCH;
                            wait_r  <= 8'd0;
                        end
                        CLS_MEM: begin
                            state_r <= ST_MEM;
                            wait_r  <= 8'd0;
                        end
                        default: begin
                            state_r <= ST_EXEC;
                        end
                    endcase
                end
                ST_EXEC: begin
                    state_r <= ST_WB;
                end
                ST_WB: begin
                    pc_r    <= pc_inc_s;
                    state_r <= ST_FETCH;
                    wait_r  <= 8'd0;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        pc_r    <= pc_inc_s;
                        state_r <= ST_FETCH;
                        wait_r  <= 8'd0;
                    end else if (wait_r == TIMEOUT_LAST) begin
                        state_r <= ST_HALT;
                        fault_r <= 1'b1;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_HALT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    // Strobes decoded from the registered state; only rf_we/rf_wd_sel see dmem_ack.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_op      = ALU_IDLE;
        alu_imm_sel = 1'b0;
        rf_we       = 1'b0;
        rf_wd_sel   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_EXEC: begin
                alu_op      = dec_alu_op_s;
                alu_imm_sel = dec_imm_sel_s;
            end
            ST_WB: begin
                rf_we = 1'b1;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_is_store_s;
                if (dmem_ack && !dec_is_store_s) begin
                    rf_we     = 1'b1;
                    rf_wd_sel = 1'b1;
                end else begin
                    rf_we     = 1'b0;
                    rf_wd_sel = 1'b0;
                end
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // I-type reads rd as operand A; STW reads rd as the store data on port B.
    assign rf_ra     = dec_imm_sel_s ? ir_rd(ir_r) : ir_ra(ir_r);
    assign rf_rb     = dec_is_store_s ? ir_rd(ir_r) : ir_rb(ir_r);
    assign rf_wa     = ir_rd(ir_r);
    assign alu_imm   = {8'h00, ir_imm8(ir_r)};
    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign busy      = (state_r != ST_HALT);
    assign fault     = fault_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: a table of instructions run through a
// scoreboard, followed by hand-written halt, timeout and reset sequences.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [3:0]  alu_op;
    logic        alu_imm_sel;
    logic [15:0] alu_imm;
    logic [2:0]  rf_ra;
    logic [2:0]  rf_rb;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic        rf_wd_sel;
    logic [15:0] pc;
    logic        busy;
    logic        fault;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] ir;
        int          dwait;
        int          cycles;
        logic [3:0]  aop;
        logic        isel;
        logic [15:0] imm;
        int          wes;
        logic [2:0]  wa;
        logic        wds;
        int          dreqs;
        logic        dwe;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];

    cpu_ctrl_fsm #(.PC_RESET(16'h0000), .MEM_TIMEOUT(4)) dut (
        .CLK         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .alu_op      (alu_op),
        .alu_imm_sel (alu_imm_sel),
        .alu_imm     (alu_imm),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd_sel   (rf_wd_sel),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a falling edge with the DUT in FETCH; returns at the falling edge
    // where the next fetch is requested (or the sequencer has halted).
    task automatic run_instr(input int idx, input vec_t v);
        vec_t o;
        vec_t e;
        bit   fetched;
        bit   done;
        int   dcnt;
        int   cyc;
        exp_q.push_back(v);
        o = '{default: 0};
        fetched = 1'b0;
        done    = 1'b0;
        dcnt    = 0;
        cyc     = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy || (fetched && imem_req)) begin
                done = 1'b1;
                break;
            end
            imem_ack   = imem_req && !fetched;
            imem_rdata = v.ir;
            dmem_ack   = dmem_req && (dcnt == v.dwait);
            #1;
            if (cyc == 1) begin
                o.ra = rf_ra;
                o.rb = rf_rb;
            end
            if (alu_op != 4'd0) begin
                o.aop  = alu_op;
                o.isel = alu_imm_sel;
                o.imm  = alu_imm;
            end
            if (rf_we) begin
                o.wes = o.wes + 1;
                o.wa  = rf_wa;
                o.wds = rf_wd_sel;
            end
            if (dmem_req) begin
                o.dreqs = o.dreqs + 1;
                o.dwe   = dmem_we;
                dcnt    = dcnt + 1;
            end
            if (imem_ack) fetched = 1'b1;
            cyc = cyc + 1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        o.cycles = cyc;
        o.pc     = pc;
        e = exp_q.pop_front();
        check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_cycles", idx), o.cycles, e.cycles);
        check($sformatf("v%0d_alu_op", idx), 32'(o.aop), 32'(e.aop));
        check($sformatf("v%0d_imm_sel", idx), 32'(o.isel), 32'(e.isel));
        check($sformatf("v%0d_alu_imm", idx), 32'(o.imm), 32'(e.imm));
        check($sformatf("v%0d_rf_we_cnt", idx), o.wes, e.wes);
        check($sformatf("v%0d_rf_wa", idx), 32'(o.wa), 32'(e.wa));
        check($sformatf("v%0d_rf_wd_sel", idx), 32'(o.wds), 32'(e.wds));
        check($sformatf("v%0d_dmem_req_cnt", idx), o.dreqs, e.dreqs);
        check($sformatf("v%0d_dmem_we", idx), 32'(o.dwe), 32'(e.dwe));
        check($sformatf("v%0d_rf_ra", idx), 32'(o.ra), 32'(e.ra));
        check($sformatf("v%0d_rf_rb", idx), 32'(o.rb), 32'(e.rb));
        check($sformatf("v%0d_pc", idx), 32'(o.pc), 32'(e.pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_req;
        bit saw_we;
        int waited;

        //          ir        dw cyc aop  isel  imm       wes wa    wds   dreq dwe   ra    rb    pc
        vecs[0]  = '{16'h05E7, 0, 4, 4'd1,  1'b1, 16'h0005, 1, 3'd7, 1'b0, 0, 1'b0, 3'd7, 3'd0, 16'h0001}; // ADDI
        vecs[1]  = '{16'h2341, 0, 4, 4'd2,  1'b0, 16'h0023, 1, 3'd2, 1'b0, 0, 1'b0, 3'd3, 3'd4, 16'h0002}; // SUB
        vecs[2]  = '{16'h0EB1, 0, 4, 4'd10, 1'b0, 16'h000E, 1, 3'd5, 1'b0, 0, 1'b0, 3'd6, 3'd1, 16'h0003}; // EQ
        vecs[3]  = '{16'hA52B, 0, 4, 4'd5,  1'b1, 16'h00A5, 1, 3'd1, 1'b0, 0, 1'b0, 3'd1, 3'd4, 16'h0004}; // XORI
        vecs[4]  = '{16'hFF0D, 0, 4, 4'd7,  1'b1, 16'h00FF, 1, 3'd0, 1'b0, 0, 1'b0, 3'd0, 3'd7, 16'h0005}; // SRI
        vecs[5]  = '{16'h0672, 1, 4, 4'd0,  1'b0, 16'h0000, 0, 3'd0, 1'b0, 2, 1'b1, 3'd6, 3'd3, 16'h0006}; // STW
        vecs[6]  = '{16'h0293, 3, 6, 4'd0,  1'b0, 16'h0000, 1, 3'd4, 1'b1, 4, 1'b0, 3'd2, 3'd0, 16'h0007}; // LDW slow
        vecs[7]  = '{16'h0733, 0, 3, 4'd0,  1'b0, 16'h0000, 1, 3'd1, 1'b1, 1, 1'b0, 3'd7, 3'd0, 16'h0008}; // LDW fast
        vecs[8]  = '{16'h070E, 0, 2, 4'd0,  1'b0, 16'h0000, 0, 3'd0, 1'b0, 0, 1'b0, 3'd7, 3'd0, 16'h0010}; // BR +7
        vecs[9]  = '{16'hFE0E, 0, 2, 4'd0,  1'b0, 16'h0000, 0, 3'd0, 1'b0, 0, 1'b0, 3'd6, 3'd7, 16'h000F}; // BR -2
        vecs[10] = '{16'hEF0E, 0, 2, 4'd0,  1'b0, 16'h0000, 0, 3'd0, 1'b0, 0, 1'b0, 3'd7, 3'd5, 16'hFFFF}; // BR -17
        vecs[11] = '{16'h000E, 0, 2, 4'd0,  1'b0, 16'h0000, 0, 3'd0, 1'b0, 0, 1'b0, 3'd0, 3'd0, 16'h0000}; // BR wrap
        vecs[12] = '{16'h80C9, 0, 4, 4'd3,  1'b1, 16'h0080, 1, 3'd6, 1'b0, 0, 1'b0, 3'd6, 3'd0, 16'h0001}; // ORI
        vecs[13] = '{16'h0019, 0, 2, 4'd0,  1'b0, 16'h0000, 0, 3'd0, 1'b0, 0, 1'b0, 3'd0, 3'd0, 16'h0001}; // illegal 25

        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        dmem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd1);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_imem_addr", 32'(imem_addr), 32'h0000);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_strobes", {26'd0, dmem_req, dmem_we, rf_we, rf_wd_sel, alu_imm_sel, 1'b0}, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_instr(i, vecs[i]);
        end

        // Halted: spurious acks must not restart anything.
        check("halt_fault", 32'(fault), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        saw_req  = 1'b0;
        saw_we   = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            saw_req = saw_req | imem_req | dmem_req;
            saw_we  = saw_we | rf_we;
            @(negedge clk);
        end
        check("halt_no_req", 32'(saw_req), 32'd0);
        check("halt_no_we", 32'(saw_we), 32'd0);
        check("halt_pc_hold", 32'(pc), 32'h0001);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("halt_rst_pc", 32'(pc), 32'h0000);
        check("halt_rst_fault", 32'(fault), 32'd0);
        check("halt_rst_busy", 32'(busy), 32'd1);
        check("halt_rst_imem_req", 32'(imem_req), 32'd1);

        // Fetch timeout with a spurious dmem_ack during FETCH.
        dmem_ack = 1'b1;
        waited   = 0;
        saw_we   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fault) break;
            if (imem_req) waited = waited + 1;
            saw_we = saw_we | rf_we;
            @(negedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        check("to_wait_cycles", waited, 4);
        check("to_fault", 32'(fault), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_we", 32'(saw_we), 32'd0);
        check("to_pc", 32'(pc), 32'h0000);

        // Reset while a load is waiting in MEM.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_instr(14, vecs[0]);
        imem_ack   = 1'b1;
        imem_rdata = 16'h0293;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("mr_dmem_req0", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #1;
        check("mr_dmem_req1", 32'(dmem_req), 32'd1);
        check("mr_pc_before", 32'(pc), 32'h0001);
        saw_we = rf_we;
        reset  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        saw_we = saw_we | rf_we;
        check("mr_dmem_req_drop", 32'(dmem_req), 32'd0);
        check("mr_fetch", 32'(imem_req), 32'd1);
        check("mr_pc", 32'(pc), 32'h0000);
        check("mr_no_we", 32'(saw_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
